// File: rtl/cv32e41p_div_iter.sv
// cv32e41p_div_iter: iterative radix-2 restoring divider, 32 cycles per op.
// Ports: clk, rst_n (async, active-low); enable_i, operator_i (00 DIVU,
// 01 DIV, 10 REMU, 11 REM), op_a_i (dividend), op_b_i (divisor) request
// an operation; result_o, ready_o, multicycle_o report it; ex_ready_i
// releases a finished result. Optional macro CV32E41P_DIV_EARLY_EXIT_EN
// lets divide-by-zero skip the iterations and finish one cycle after
// acceptance.
module cv32e41p_div_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [1:0]  operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic [31:0] result_o,
    output logic        multicycle_o,
    output logic        ready_o,
    input  logic        ex_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINISH
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] div_q;
    logic        q_sign_q;
    logic        r_sign_q;
    logic        div_zero_q;

    // Operand conditioning at acceptance
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        b_zero;
    logic        early_exit;
    logic [31:0] early_result;

    assign is_signed    = operator_i[0];
    assign a_neg        = is_signed & op_a_i[31];
    assign b_neg        = is_signed & op_b_i[31];
    assign a_abs        = a_neg ? (32'd0 - op_a_i) : op_a_i;
    assign b_abs        = b_neg ? (32'd0 - op_b_i) : op_b_i;
    assign b_zero       = (op_b_i == 32'd0);
    assign early_result = operator_i[1] ? op_a_i : 32'hFFFF_FFFF;

`ifdef CV32E41P_DIV_EARLY_EXIT_EN
    assign early_exit = b_zero;
`else
    assign early_exit = 1'b0;
`endif

    // One restoring step. The partial remainder is 33 bits wide because
    // rem < divisor may already use bit 31 before the shift.
    logic [32:0] partial;
    logic [32:0] trial;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    assign partial = {rem_q, quo_q[31]};
    assign trial   = partial - {1'b0, div_q};
    assign rem_nxt = trial[32] ? partial[31:0] : trial[31:0];
    assign quo_nxt = {quo_q[30:0], ~trial[32]};

    // Sign fix-up applied on the final step. A zero divisor leaves the
    // all-ones quotient untouched.
    logic        neg_quo;
    logic        neg_rem;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fin_result;

    assign neg_quo    = op_q[0] & q_sign_q & ~div_zero_q;
    assign neg_rem    = op_q[0] & r_sign_q;
    assign quo_fix    = neg_quo ? (32'd0 - quo_nxt) : quo_nxt;
    assign rem_fix    = neg_rem ? (32'd0 - rem_nxt) : rem_nxt;
    assign fin_result = op_q[1] ? rem_fix : quo_fix;

    // Unit is free in IDLE only when no request is pending
    assign ready_o = (state == FINISH) | ((state == IDLE) & ~enable_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            op_q         <= 2'b00;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            div_q        <= 32'd0;
            q_sign_q     <= 1'b0;
            r_sign_q     <= 1'b0;
            div_zero_q   <= 1'b0;
            result_o     <= 32'd0;
            multicycle_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        op_q       <= operator_i;
                        rem_q      <= 32'd0;
                        quo_q      <= a_abs;
                        div_q      <= b_abs;
                        q_sign_q   <= op_a_i[31] ^ op_b_i[31];
                        r_sign_q   <= op_a_i[31];
                        div_zero_q <= b_zero;
                        cnt        <= 5'd31;
                        if (early_exit) begin
                            state    <= FINISH;
                            result_o <= early_result;
                        end else begin
                            state        <= ITER;
                            multicycle_o <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state        <= FINISH;
                        result_o     <= fin_result;
                        multicycle_o <= 1'b0;
                    end
                end
                FINISH: begin
                    if (ex_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    multicycle_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e41p_div_iter.sv
// tb_cv32e41p_div_iter: directed bench for the iterative divider.
// Expected results and latencies are queued at issue and checked at FINISH.
module tb_cv32e41p_div_iter;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic [1:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] result_o;
    logic        multicycle_o;
    logic        ready_o;
    logic        ex_ready_i;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    logic [31:0] exp_res_q[$];
    int          exp_lat_q[$];

    cv32e41p_div_iter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .operator_i   (operator_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .result_o     (result_o),
        .multicycle_o (multicycle_o),
        .ready_o      (ready_o),
        .ex_ready_i   (ex_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int lat_of(input logic [31:0] b);
`ifdef CV32E41P_DIV_EARLY_EXIT_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Issue one op, wait for FINISH, hold it for `hold` cycles with
    // stray enable pulses, then release it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int lat;
        logic [31:0] er;
        int el;
        exp_res_q.push_back(model(op, a, b));
        exp_lat_q.push_back(lat_of(b));
        @(negedge clk);
        enable_i   = 1'b1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        ex_ready_i = 1'b0;
        #1 chk("idle_req_ready", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        enable_i   = 1'b0;
        operator_i = 2'($urandom);
        op_a_i     = $urandom;
        op_b_i     = $urandom;
        lat = 1;
        while (!ready_o && lat < 40) begin
            chk("iter_mc", 32'(multicycle_o), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        chk("latency", 32'(lat), 32'(el));
        chk("result", result_o, er);
        chk("fin_mc", 32'(multicycle_o), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            enable_i   = 1'b1;
            operator_i = 2'($urandom);
            op_a_i     = $urandom;
            op_b_i     = $urandom;
            @(posedge clk);
            #1;
            chk("hold_ready", 32'(ready_o), 32'd1);
            chk("hold_result", result_o, er);
        end
        @(negedge clk);
        enable_i   = 1'b0;
        ex_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", 32'(ready_o), 32'd1);
        chk("idle_mc", 32'(multicycle_o), 32'd0);
        @(negedge clk);
        enable_i = 1'b1;
        #1 chk("back_in_idle", 32'(ready_o), 32'd0);
        enable_i   = 1'b0;
        ex_ready_i = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        operator_i = 2'b00;
        op_a_i     = 32'd0;
        op_b_i     = 32'd0;
        ex_ready_i = 1'b0;
        #12;
        chk("rst_result", result_o, 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_mc", 32'(multicycle_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'd100, 32'd7, 0);
        run_op(2'b10, 32'd100, 32'd7, 0);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b01, 32'hFFFF_FFFB, 32'd0, 0);
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 0);
        run_op(2'b00, 32'h1234_5678, 32'd0, 0);
        run_op(2'b10, 32'h1234_5678, 32'd0, 0);
        run_op(2'b01, 32'd100, 32'hFFFF_FFF9, 0);
        run_op(2'b11, 32'd100, 32'hFFFF_FFF9, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'hFFFF_FFFE, 32'h8000_0001, 0);
        run_op(2'b00, 32'd5, 32'd9, 5);
        for (int i = 0; i < 6; i++)
            run_op(2'($urandom), $urandom, $urandom >> $urandom_range(0, 31), 0);

        // Reset in the middle of an iteration, then re-issue
        @(negedge clk);
        enable_i   = 1'b1;
        operator_i = 2'b00;
        op_a_i     = 32'hFFFF_FFFF;
        op_b_i     = 32'd3;
        @(posedge clk);
        #1 enable_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_result", result_o, 32'd0);
        chk("abort_ready", 32'(ready_o), 32'd1);
        chk("abort_mc", 32'(multicycle_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 32'hFFFF_FFFF, 32'd3, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/cv32e41p_div_iter.md
CV32E41P_DIV_ITER -- requirements
Module: cv32e41p_div_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port enable_i, input, 1 bit: request a division operation.
REQ-004 SHALL have port operator_i, input, 2 bits: 00 DIVU, 01 DIV, 10 REMU, 11 REM.
REQ-005 SHALL have port op_a_i, input, 32 bits: dividend.
REQ-006 SHALL have port op_b_i, input, 32 bits: divisor.
REQ-007 SHALL have port result_o, output, 32 bits: quotient or remainder.
REQ-008 SHALL have port multicycle_o, output, 1 bit: high while iterating.
REQ-009 SHALL have port ready_o, output, 1 bit: result valid / unit free.
REQ-010 SHALL have port ex_ready_i, input, 1 bit: consumer accepts result.

Function
REQ-011 SHALL implement FSM states IDLE, ITER and FINISH.
REQ-012 In IDLE, ready_o SHALL be 1 when enable_i=0 and 0 when enable_i=1.
REQ-013 An operation SHALL be accepted in IDLE with enable_i=1; the accepting cycle is T.
REQ-014 At acceptance, the unit SHALL latch operator_i, |op_a_i|, |op_b_i|, the quotient sign, the remainder sign and a divisor-zero flag.
- Absolute values SHALL be taken only for signed ops (DIV, REM).
- Inputs may change after T.
REQ-015 The unit SHALL move to ITER with a 5-bit counter at 31.
REQ-016 ITER SHALL perform one radix-2 restoring step per cycle.
- Shift {rem, quo} left by 1.
- Compute a 33-bit trial subtraction rem-divisor.
- If the trial result is non-negative, write it back and set quo[0]=1.
REQ-017 ITER SHALL last exactly 32 cycles, with multicycle_o=1 and ready_o=0; the counter wraps from 0 into FINISH.
REQ-018 FINISH SHALL be entered at T+33.
- result_o is valid there with ready_o=1 and multicycle_o=0.
- result_o SHALL be held stable while in FINISH.
REQ-019 In FINISH with ex_ready_i=1, the unit SHALL return to IDLE next cycle; with ex_ready_i=0 it SHALL hold FINISH indefinitely.
REQ-020 enable_i SHALL be ignored outside IDLE; back-to-back operations require one IDLE cycle.
REQ-021 For signed ops, the quotient SHALL be negated when the signs differ and the divisor is non-zero; the remainder SHALL take the dividend's sign.
REQ-022 Divide by zero SHALL give quotient 0xFFFFFFFF for DIV and DIVU, and remainder = op_a for REM and REMU.
REQ-023 Overflow 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0.
REQ-024 result_o SHALL be driven from registers only, with no combinational path from op_a_i or op_b_i.

Reset
REQ-025 On rst_n=0, the FSM SHALL go to IDLE immediately.
- result_o=0, multicycle_o=0, counter=0 and all datapath registers cleared.
- ready_o=1 provided enable_i=0.
REQ-026 Reset during ITER or FINISH SHALL abort the operation with no residual state; the first post-reset acceptance behaves as from power-up.

Configuration
REQ-027 Macro CV32E41P_DIV_EARLY_EXIT_EN SHALL control the early-exit feature.
- Defined: a divisor-zero operation SHALL skip ITER, going IDLE to FINISH at T+1 with the REQ-022 result.
- Defined: multicycle_o SHALL stay 0 for such an operation.
- Undefined: every operation SHALL take 32 ITER cycles (FINISH at T+33); results are identical either way.

Verification
REQ-028 DIVU 100/7 -> FINISH at T+33, result_o=14; with REMU, result_o=2.
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> result_o=0x80000000; REM -> 0.
REQ-031 DIV 0xFFFFFFFB / 0 -> result_o=0xFFFFFFFF; REM -> 0xFFFFFFFB.
- With the macro defined, FINISH at T+1.
- Without it, FINISH at T+33.
REQ-032 Hold ex_ready_i=0 for 5 cycles in FINISH -> ready_o=1 and result_o stable throughout; enable_i pulses ignored; IDLE entered one cycle after ex_ready_i=1.
REQ-033 Assert rst_n=0 at iteration 10 of DIVU 0xFFFFFFFF/3 -> immediate IDLE with result_o=0; then re-issue -> 0x55555555 at T+33.
